// File: rtl/comparator_4b_bist.sv
// On-chip vector generator and response checker for an external 4-bit cascadable comparator.
// Define COMPARATOR_4B_BIST_STOP_ON_ERR_EN to end a run at the first mismatching vector.
`timescale 1ns/1ps

module comparator_4b_bist (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  a,
    output logic [3:0]  b,
    output logic        in_l,
    output logic        in_g,
    output logic        in_m,
    input  logic        dut_l,
    input  logic        dut_g,
    input  logic        dut_m,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [22:0] test_cnt,
    output logic [22:0] err_cnt
);

    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  APPLY    = 2'd1;
    localparam logic [1:0]  CHECK    = 2'd2;
    localparam logic [1:0]  DONE     = 2'd3;
    localparam logic [9:0]  LAST_IDX = 10'h2FF;
    localparam logic [22:0] CNT_MAX  = 23'h7FFFFF;

    logic [1:0] state;
    logic [9:0] idx;
    logic [2:0] cas_lgm;
    logic [2:0] exp_lgm;
    logic       mismatch;

    // Cascade pattern for the current vector; cas=3 never occurs.
    always_comb begin
        cas_lgm = 3'b000;
        case (idx[9:8])
            2'd0:    cas_lgm = 3'b001;
            2'd1:    cas_lgm = 3'b100;
            2'd2:    cas_lgm = 3'b010;
            default: cas_lgm = 3'b000;
        endcase
    end

    always_comb begin
        exp_lgm = cas_lgm;
        if (idx[7:4] < idx[3:0])
            exp_lgm = 3'b100;
        else if (idx[7:4] > idx[3:0])
            exp_lgm = 3'b010;
    end

    assign mismatch = ({dut_l, dut_g, dut_m} != exp_lgm);

    // Stimulus is zero in IDLE and otherwise follows idx, which holds through DONE.
    always_comb begin
        a    = 4'h0;
        b    = 4'h0;
        in_l = 1'b0;
        in_g = 1'b0;
        in_m = 1'b0;
        if (state != IDLE) begin
            a                  = idx[7:4];
            b                  = idx[3:0];
            {in_l, in_g, in_m} = cas_lgm;
        end
    end

    assign busy = (state == APPLY) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == 23'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 10'd0;
            test_cnt <= 23'd0;
            err_cnt  <= 23'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= APPLY;
                        idx      <= 10'd0;
                        test_cnt <= 23'd0;
                        err_cnt  <= 23'd0;
                    end
                end
                APPLY: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (test_cnt != CNT_MAX)
                        test_cnt <= test_cnt + 23'd1;
                    if (mismatch && (err_cnt != CNT_MAX))
                        err_cnt <= err_cnt + 23'd1;
`ifdef COMPARATOR_4B_BIST_STOP_ON_ERR_EN
                    if (mismatch || (idx == LAST_IDX)) begin
                        state <= DONE;
                    end else begin
                        state <= APPLY;
                        idx   <= idx + 10'd1;
                    end
`else
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        state <= APPLY;
                        idx   <= idx + 10'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_4b_bist.sv
// Self-checking bench: emulates the comparator under test (golden, stuck-at and random faults)
// and checks the BIST verdict against counts computed from the comparator's rules.
`timescale 1ns/1ps

module tb_comparator_4b_bist;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        in_l;
    logic        in_g;
    logic        in_m;
    logic        dut_l;
    logic        dut_g;
    logic        dut_m;
    logic        busy;
    logic        done;
    logic        pass;
    logic [22:0] test_cnt;
    logic [22:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // 0 golden, 1 equal output stuck at 0, 2 less output stuck at 1, 3 random flips
    int         mode = 0;
    logic [2:0] flips [768];
    bit         order_check = 1'b0;
    logic [2:0] resp;

    comparator_4b_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .in_l(in_l), .in_g(in_g), .in_m(in_m),
        .dut_l(dut_l), .dut_g(dut_g), .dut_m(dut_m),
        .busy(busy), .done(done), .pass(pass),
        .test_cnt(test_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] casPattern(input int cas);
        case (cas)
            0:       return 3'b001;
            1:       return 3'b100;
            2:       return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int casOf(input logic [2:0] pat);
        for (int c = 0; c < 3; c++)
            if (casPattern(c) == pat) return c;
        return 3;
    endfunction

    function automatic logic [2:0] refLgm(input int av, input int bv, input logic [2:0] cin);
        if (av < bv) return 3'b100;
        if (av > bv) return 3'b010;
        return cin;
    endfunction

    // Behavioural model of the comparator being tested, optionally faulty.
    always_comb begin
        resp = refLgm(int'(a), int'(b), {in_l, in_g, in_m});
        case (mode)
            1: resp[0] = 1'b0;
            2: resp[2] = 1'b1;
            3: if (casOf({in_l, in_g, in_m}) < 3)
                   resp = resp ^ flips[casOf({in_l, in_g, in_m}) * 256 + int'(a) * 16 + int'(b)];
            default: ;
        endcase
    end
    assign {dut_l, dut_g, dut_m} = resp;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Order monitor: vectors must appear b-inner, a-middle, cas-outer, two cycles each.
    int  prev_vec = 0;
    int  hold = 0;
    bit  prev_busy = 1'b0;
    always @(negedge clk) begin
        int vec;
        vec = casOf({in_l, in_g, in_m}) * 256 + int'(a) * 16 + int'(b);
        if (order_check) begin
            if (busy && !prev_busy) begin
                checkOutput("first_vec", vec, 0);
                hold = 1;
            end else if (busy) begin
                if (vec == prev_vec) hold++;
                else begin
                    checkOutput("vec_hold", hold, 2);
                    checkOutput("vec_next", vec, prev_vec + 1);
                    hold = 1;
                end
            end else if (prev_busy) begin
                checkOutput("last_hold", hold, 2);
            end
        end
        prev_vec  = vec;
        prev_busy = busy;
    end

    task automatic applyStimulus(input bit hold_start, output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles = 1;
        #1;
        if (!hold_start) start = 1'b0;
        checkOutput("cleared_after_start", {done, pass, busy, test_cnt}, {3'b001, 23'd0});
        while (!done && cycles < 3000) begin
            @(posedge clk);
            cycles++;
            #1;
        end
        start = 1'b0;
        if (!done) checkOutput("run_timeout", 0, 1);
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_vec"}, {a, b, in_l, in_g, in_m}, 0);
        checkOutput({tag, "_flags"}, {busy, done, pass}, 0);
        checkOutput({tag, "_test_cnt"}, test_cnt, 0);
        checkOutput({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic checkVerdict(input string tag, input int exp_test, input int exp_err, input int last_vec);
        checkOutput({tag, "_test_cnt"}, test_cnt, exp_test);
        checkOutput({tag, "_err_cnt"}, err_cnt, exp_err);
        checkOutput({tag, "_pass"}, pass, (exp_err == 0));
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_vec"}, {a, b, in_l, in_g, in_m},
                    {last_vec[7:4], last_vec[3:0], casPattern(last_vec / 256)});
    endtask

    initial begin
        int cycles;
        int exp_err;
        int first_bad;
        int waited;

        // Asynchronous reset forces everything to zero before any clock edge.
        #2;
        checkIdleZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkIdleZero("post_reset_idle");

        // Golden comparator with order monitoring; sample edge counts as cycle 1.
        mode = 0;
        order_check = 1'b1;
        applyStimulus(1'b0, cycles);
        checkOutput("golden_cycles", cycles, 1537);
        checkVerdict("golden", 768, 0, 767);
        @(negedge clk);
        order_check = 1'b0;

        // Equal output stuck at 0: only a==b with cas=0 expects m=1.
        mode = 1;
        applyStimulus(1'b0, cycles);
`ifdef COMPARATOR_4B_BIST_STOP_ON_ERR_EN
        checkVerdict("m_stuck0", 1, 1, 0);
`else
        checkVerdict("m_stuck0", 768, 16, 767);
`endif

        // Less output stuck at 1: passes only where l is expected high.
        mode = 2;
        applyStimulus(1'b0, cycles);
`ifdef COMPARATOR_4B_BIST_STOP_ON_ERR_EN
        checkVerdict("l_stuck1", 1, 1, 0);
`else
        checkVerdict("l_stuck1", 768, 768 - (120 * 3 + 16), 767);
`endif

        // Random bit flips on a sparse set of vectors.
        exp_err = 0;
        first_bad = -1;
        for (int i = 0; i < 768; i++) begin
            flips[i] = ($urandom_range(15) == 0) ? 3'($urandom_range(7, 1)) : 3'b000;
        end
        if (flips[300] == 3'b000 && $urandom_range(1) == 1) flips[300] = 3'b010;
        for (int i = 0; i < 768; i++) begin
            if (flips[i] != 3'b000) begin
                exp_err++;
                if (first_bad < 0) first_bad = i;
            end
        end
        mode = 3;
        applyStimulus(1'b0, cycles);
`ifdef COMPARATOR_4B_BIST_STOP_ON_ERR_EN
        if (first_bad < 0) checkVerdict("random", 768, 0, 767);
        else               checkVerdict("random", first_bad + 1, 1, first_bad);
`else
        checkOutput("random_cycles", cycles, 1537);
        checkVerdict("random", 768, exp_err, 767);
`endif

        // Start held high for the whole run must not restart it.
        mode = 0;
        applyStimulus(1'b1, cycles);
        checkOutput("held_start_cycles", cycles, 1537);
        checkVerdict("held_start", 768, 0, 767);
        repeat (2) @(negedge clk);
        checkOutput("held_start_stays_done", {done, test_cnt}, {1'b1, 23'd768});

        // Reset at vector 300 aborts the run and leaves the block idle.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (test_cnt != 23'd300 && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("reached_vec300", test_cnt, 300);
        rst_n = 1'b0;
        #1;
        checkIdleZero("mid_run_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkIdleZero("after_abort_idle");
        applyStimulus(1'b0, cycles);
        checkOutput("rerun_cycles", cycles, 1537);
        checkVerdict("rerun", 768, 0, 767);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
